// File: rtl/seg7_scan.sv
// seg7_scan: double-buffered multiplexed 7-segment BCD scanner; define SCAN_HEX_EN to show hex glyphs for codes 10..15.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  scan_clk,
    input  logic                  scan_rst_n,
    input  logic                  scan_load_in,
    input  logic [4*DIGITS-1:0]   scan_value_in,
    input  logic                  scan_blank_in,
    output logic [6:0]            scan_seg_out,
    output logic [DIGITS-1:0]     scan_dig_out,
    output logic                  scan_frame_out,
    output logic                  scan_pending_out
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_TC   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]          r_pre;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_shd;
    logic [4*DIGITS-1:0]    r_dsp;
    logic                   r_pending;
    logic [6:0]             r_seg;
    logic [DIGITS-1:0]      r_dig;
    logic                   r_frame;

    logic                   w_tc;
    logic                   w_fb;
    logic [IW-1:0]          w_idx_nxt;
    logic [3:0]             w_nibs [DIGITS];
    logic [DIGITS-1:0]      w_hi_zero;
    logic [DIGITS-1:0]      w_onehot;
    logic                   w_blank;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0:    f_seg = 7'b1111110;
            4'h1:    f_seg = 7'b0110000;
            4'h2:    f_seg = 7'b1101101;
            4'h3:    f_seg = 7'b1111001;
            4'h4:    f_seg = 7'b0110011;
            4'h5:    f_seg = 7'b1011011;
            4'h6:    f_seg = 7'b1011111;
            4'h7:    f_seg = 7'b1110000;
            4'h8:    f_seg = 7'b1111111;
            4'h9:    f_seg = 7'b1111011;
`ifdef SCAN_HEX_EN
            4'hA:    f_seg = 7'b1110111;
            4'hB:    f_seg = 7'b0011111;
            4'hC:    f_seg = 7'b1001110;
            4'hD:    f_seg = 7'b0111101;
            4'hE:    f_seg = 7'b1001111;
            4'hF:    f_seg = 7'b1000111;
`endif
            default: f_seg = 7'b0000000;
        endcase
    endfunction

    // w_hi_zero[k]: every nibble from k up to the top digit is zero
    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_nib
        assign w_nibs[g]    = r_dsp[4*g +: 4];
        assign w_hi_zero[g] = (r_dsp >> (4*g)) == '0;
    end

    assign w_tc      = r_pre == PRE_TC;
    assign w_fb      = w_tc && (r_idx == IDX_LAST);
    assign w_idx_nxt = !w_tc ? r_idx : (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    assign w_onehot  = DIGITS'(1) << r_idx;
    assign w_blank   = scan_blank_in && (r_idx != '0) && w_hi_zero[r_idx];

    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            r_pre     <= '0;
            r_idx     <= '0;
            r_shd     <= '0;
            r_dsp     <= '0;
            r_pending <= 1'b0;
            r_seg     <= '0;
            r_dig     <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_pre     <= w_tc ? '0 : r_pre + PW'(1);
            r_idx     <= w_idx_nxt;
            if (scan_load_in)
                r_shd <= scan_value_in;
            // a load landing on the frame boundary bypasses the shadow
            if (w_fb && scan_load_in)
                r_dsp <= scan_value_in;
            else if (w_fb && r_pending)
                r_dsp <= r_shd;
            r_pending <= w_fb ? 1'b0 : (r_pending | scan_load_in);
            r_seg     <= w_blank ? '0 : f_seg(w_nibs[r_idx]);
            r_dig     <= (r_pre == '0) ? '0 : w_onehot;
            r_frame   <= w_fb;
        end
    end

    assign scan_seg_out     = r_seg;
    assign scan_dig_out     = r_dig;
    assign scan_frame_out   = r_frame;
    assign scan_pending_out = r_pending;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan;
    localparam int D = 4;
    localparam int S = 4;
    localparam int F = D * S;
`ifdef SCAN_HEX_EN
    localparam logic [6:0] HA = 7'b1110111, HC = 7'b1001110, HF = 7'b1000111;
`else
    localparam logic [6:0] HA = 7'b0, HC = 7'b0, HF = 7'b0;
`endif
    localparam logic [6:0] Z = 7'b1111110;

    logic        clk = 0, rst_n = 0, load = 0, blank = 0;
    logic [15:0] val = '0;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame, pend;

    seg7_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .scan_clk(clk), .scan_rst_n(rst_n), .scan_load_in(load),
        .scan_value_in(val), .scan_blank_in(blank), .scan_seg_out(seg),
        .scan_dig_out(dig), .scan_frame_out(frame), .scan_pending_out(pend)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    int total = 0, bad = 0;
    typedef struct { logic [3:0] dig; logic [6:0] seg; } exp_t;
    exp_t q[$];
    exp_t cur;
    logic [3:0] prev = '0, ed;
    bit active = 0;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cyc %0d)", name, cyc);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 3*F; i++) begin
            @(negedge clk);
            if (cyc % F == p) return;
        end
        timeout("wait_phase");
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 3*F; i++) begin
            @(negedge clk);
            if (frame === 1'b1) return;
        end
        timeout("wait_frame");
    endtask

    task automatic push4(input logic [6:0] s0, s1, s2, s3);
        q.push_back('{4'b0001, s0});
        q.push_back('{4'b0010, s1});
        q.push_back('{4'b0100, s2});
        q.push_back('{4'b1000, s3});
    endtask

    task automatic run_vec(input logic [15:0] v, input logic b, input logic [6:0] s0, s1, s2, s3);
        wait_phase(5);
        val  = v;
        load = 1;
        @(negedge clk);
        load = 0;
        chk("pend_rise", pend, 1);
        wait_frame();
        chk("pend_fall", pend, 0);
        blank = b;
        push4(s0, s1, s2, s3);
    endtask

    // Monitor: checks scan timing every cycle and pops one expectation per newly lit slot
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_seg", seg, 0);
                chk("rst_dig", dig, 0);
                chk("rst_frame", frame, 0);
                chk("rst_pend", pend, 0);
                prev   = '0;
                active = 0;
            end else begin
                n  = cyc;
                ed = (n == 0 || (n - 1) % S == 0) ? 4'b0 : 4'b1 << (((n - 1) / S) % D);
                chk("dig_seq", dig, ed);
                chk("frame", frame, n > 0 && n % F == 0);
                if (dig != 0 && dig != prev) begin
                    if (q.size() > 0) begin
                        cur    = q.pop_front();
                        active = 1;
                        chk("slot_dig", dig, cur.dig);
                        chk("slot_seg", seg, cur.seg);
                    end else
                        active = 0;
                end else if (dig != 0 && active)
                    chk("hold_seg", seg, cur.seg);
                prev = dig;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1;
        push4(Z, Z, Z, Z);
        run_vec(16'h1234, 0, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);
        run_vec(16'h0042, 1, 7'b1101101, 7'b0110011, 7'b0, 7'b0);
        run_vec(16'h0000, 1, Z, 7'b0, 7'b0, 7'b0);
        run_vec(16'h0042, 0, 7'b1101101, 7'b0110011, Z, Z);
        run_vec(16'h0102, 1, 7'b1101101, Z, 7'b0110000, 7'b0);
        run_vec(16'hA000, 1, Z, Z, Z, HA);
        run_vec(16'hAF0C, 1, HC, Z, HF, HA);
        // double buffering: second load overwrites the shadow before the boundary
        wait_phase(5);
        val = 16'h1111; load = 1;
        @(negedge clk); load = 0;
        @(negedge clk); val = 16'h2222; load = 1;
        @(negedge clk); load = 0;
        chk("dbuf_pend", pend, 1);
        wait_frame();
        chk("dbuf_pend_fall", pend, 0);
        blank = 0;
        push4(7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101);
        // load exactly on the frame boundary
        wait_phase(F - 1);
        val = 16'h9876; load = 1;
        @(negedge clk); load = 0;
        chk("fb_frame", frame, 1);
        chk("fb_pend", pend, 0);
        push4(7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011);
        @(negedge clk);
        chk("fb_pend_hold", pend, 0);
        wait_frame();
        // reset with a value pending discards it
        wait_phase(5);
        val = 16'h5555; load = 1;
        @(negedge clk); load = 0;
        chk("mr_pend", pend, 1);
        @(negedge clk); rst_n = 0;
        #1;
        chk("mr_pend_clr", pend, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        push4(Z, Z, Z, Z);
        wait_frame();
        wait_frame();
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
